sprite_motion_ctrl: RTL

//   Frame-synchronous motion controller for the bouncing-picture VGA demo. Watches the
//   h_addr/v_addr scan position from vga_ctrl and advances the picture origin once per frame

---
 rtl/sprite_motion_ctrl_if.sv | 10 +
 rtl/sprite_motion_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sprite_motion_ctrl_if.sv
// Host position-load port: valid/ready handshake carrying the requested picture origin.
interface sprite_motion_ctrl_if;
    logic       set_valid;
    logic       set_ready;
    logic [9:0] set_x;
    logic [8:0] set_y;

    modport master (output set_valid, output set_x, output set_y, input set_ready);
    modport slave  (input set_valid, input set_x, input set_y, output set_ready);
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous motion controller for the bouncing picture: advances the origin
// once per frame with edge bounce, accepts host loads, and decodes the picture window.
module sprite_motion_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned PIC_W    = 256,
    parameter int unsigned PIC_H    = 192,
    parameter int unsigned STEP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_addr,
    input  logic [9:0]        v_addr,
    input  logic              enable,
    input  logic [STEP_W-1:0] step_x,
    input  logic [STEP_W-1:0] step_y,
    sprite_motion_ctrl_if.slave set,
    output logic [9:0]        x_pos,
    output logic [8:0]        y_pos,
    output logic              x_dir,
    output logic              y_dir,
    output logic [1:0]        bounce,
    output logic [15:0]       frame_cnt,
    output logic              in_pic,
    output logic [7:0]        pic_h,
    output logic [7:0]        pic_v
);

    localparam int unsigned X_MAX = H_ACTIVE - PIC_W;
    localparam int unsigned Y_MAX = V_ACTIVE - PIC_H;

    typedef enum logic [1:0] {IDLE, RUN, UPD} state_t;

    state_t      state_q, state_d;
    logic        prev_eof;
    logic        eof, tick, xfer;
    logic [10:0] x_sum, y_sum;
    logic [9:0]  x_nxt, set_x_cl;
    logic [8:0]  y_nxt, set_y_cl;
    logic        x_dir_nxt, y_dir_nxt, x_hit, y_hit;

    // Last visible pixel of the frame; tick fires once even if the scan position is held
    assign eof  = (h_addr == 10'(H_ACTIVE - 1)) && (v_addr == 10'(V_ACTIVE - 1));
    assign tick = eof & ~prev_eof;

    // No loads while the origin is being rewritten
    assign set.set_ready = (state_q != UPD);
    assign xfer          = set.set_valid & set.set_ready;

    assign set_x_cl = (set.set_x > 10'(X_MAX)) ? 10'(X_MAX) : set.set_x;
    assign set_y_cl = (set.set_y > 9'(Y_MAX))  ? 9'(Y_MAX)  : set.set_y;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: a tick in RUN schedules one update unless a host load claims that frame
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN: begin
                if (!enable)           state_d = IDLE;
                else if (tick && !xfer) state_d = UPD;
            end
            UPD:     state_d = enable ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Horizontal step with bounce at 0 and X_MAX
    always_comb begin
        x_sum     = 11'(x_pos) + 11'(step_x);
        x_nxt     = x_pos;
        x_dir_nxt = x_dir;
        x_hit     = 1'b0;
        if (step_x != '0) begin
            if (!x_dir) begin
                if (x_sum >= 11'(X_MAX)) begin
                    x_nxt = 10'(X_MAX); x_dir_nxt = 1'b1; x_hit = 1'b1;
                end else begin
                    x_nxt = x_sum[9:0];
                end
            end else if (11'(x_pos) <= 11'(step_x)) begin
                x_nxt = '0; x_dir_nxt = 1'b0; x_hit = 1'b1;
            end else begin
                x_nxt = x_pos - 10'(step_x);
            end
        end
    end

    // Vertical step with bounce at 0 and Y_MAX
    always_comb begin
        y_sum     = 11'(y_pos) + 11'(step_y);
        y_nxt     = y_pos;
        y_dir_nxt = y_dir;
        y_hit     = 1'b0;
        if (step_y != '0) begin
            if (!y_dir) begin
                if (y_sum >= 11'(Y_MAX)) begin
                    y_nxt = 9'(Y_MAX); y_dir_nxt = 1'b1; y_hit = 1'b1;
                end else begin
                    y_nxt = y_sum[8:0];
                end
            end else if (11'(y_pos) <= 11'(step_y)) begin
                y_nxt = '0; y_dir_nxt = 1'b0; y_hit = 1'b1;
            end else begin
                y_nxt = y_pos - 9'(step_y);
            end
        end
    end

    // Origin, direction, bounce pulse and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_eof  <= 1'b0;
            x_pos     <= '0;
            y_pos     <= '0;
            x_dir     <= 1'b0;
            y_dir     <= 1'b0;
            bounce    <= '0;
            frame_cnt <= '0;
        end else begin
            prev_eof <= eof;
            bounce   <= '0;
            if (tick) frame_cnt <= frame_cnt + 16'd1;
            if (xfer) begin
                x_pos <= set_x_cl;
                y_pos <= set_y_cl;
            end else if (state_q == UPD) begin
                x_pos  <= x_nxt;
                y_pos  <= y_nxt;
                x_dir  <= x_dir_nxt;
                y_dir  <= y_dir_nxt;
                bounce <= {y_hit, x_hit};
            end
        end
    end

    // Picture window decode for the ROM address and pixel mux
    assign in_pic = (h_addr >= x_pos) &&
                    (11'(h_addr) < 11'(x_pos) + 11'(PIC_W)) &&
                    (11'(v_addr) >= 11'(y_pos)) &&
                    (11'(v_addr) < 11'(y_pos) + 11'(PIC_H));
    assign pic_h  = 8'(h_addr - x_pos);
    assign pic_v  = 8'(v_addr - 10'(y_pos));

endmodule
